// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter and its FIFO.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; head word is read combinationally.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_c,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Pushes and pops are qualified by the registered flags only.
    always_comb begin
        do_push  = push_i && !full_q;
        do_pop   = pop_i && !empty_q;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_c = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter: FIFO-buffered words serialised LSB-first with
// start bit, optional parity and 1 or 2 stop bits; frames run back-to-back.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [DATA_W-1:0]             data_in,
    output logic                          tx1,
    output logic                          parallel_in_active,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned DIV_W = cnt_w(CLKS_PER_BIT);
    localparam int unsigned BIT_W = cnt_w(DATA_W);

    localparam logic             PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 active_q, active_d;
    logic                 ovf_q, ovf_d;
    logic                 div_tc;
    logic                 pop;

    logic [DATA_W-1:0]    fifo_rdata;
    logic                 fifo_empty;
    logic                 fifo_full_w;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_w;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (load && !fifo_full_w),
        .pop_i   (pop),
        .wdata_i (data_in),
        .rdata_c (fifo_rdata),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty),
        .count_o (fifo_count_w)
    );

    // Next-state logic; line value is derived from the state being entered so tx1 is registered.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        div_tc  = (div_q == DIV_LAST);
        ovf_d   = load && fifo_full_w;

        if (state_q != IDLE) begin
            div_d = div_tc ? '0 : div_q + DIV_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                pop = !fifo_empty;
            end
            START: begin
                if (div_tc) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (div_tc) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    end
                end
            end
            PARITY: begin
                if (div_tc) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (div_tc) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                        pop     = !fifo_empty;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A pop always launches a fresh frame from the FIFO head.
        if (pop) begin
            state_d = START;
            div_d   = '0;
            bit_d   = '0;
            shift_d = fifo_rdata;
            par_d   = (^fifo_rdata) ^ PAR_MODE;
        end

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            active_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            active_q <= active_d;
            ovf_q    <= ovf_d;
        end
    end

    assign tx1                = tx_q;
    assign parallel_in_active = active_q;
    assign fifo_full          = fifo_full_w;
    assign fifo_count         = fifo_count_w;
    assign overflow           = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench for uart_tx_fifo_param over several parameter sets, with a
// queue/countdown reference model and a line monitor decoding whole frames.
`timescale 1ns/1ps
module tb_uart_tx_fifo_param;

    localparam int NCFG      = 6;
    localparam int CYC_LIMIT = 5000;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic rst_go   = 1'b0;
    logic rst_req  = 1'b0;
    logic rst_done = 1'b0;
    logic all_done;

    always #5 clk = ~clk;

    function automatic int cfg_dw(input int g); return (g == 4) ? 5 : (g == 5) ? 9 : 8; endfunction
    function automatic int cfg_c (input int g); return (g == 3) ? 1 : (g == 4) ? 3 : (g == 5) ? 2 : 4; endfunction
    function automatic int cfg_pe(input int g); return (g == 1 || g == 2 || g == 4 || g == 5) ? 1 : 0; endfunction
    function automatic int cfg_po(input int g); return (g == 2 || g == 4) ? 1 : 0; endfunction
    function automatic int cfg_sb(input int g); return (g == 3 || g == 4) ? 2 : 1; endfunction
    function automatic int cfg_d (input int g); return (g == 4) ? 2 : (g == 5) ? 8 : 4; endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int DW    = cfg_dw(g);
        localparam int C     = cfg_c(g);
        localparam int PE    = cfg_pe(g);
        localparam int PO    = cfg_po(g);
        localparam int SB    = cfg_sb(g);
        localparam int D     = cfg_d(g);
        localparam int NB    = 1 + DW + PE + SB;
        localparam int FRAME = NB * C;

        logic                   load;
        logic [DW-1:0]          din;
        logic                   tx, act, full, ovf;
        logic [$clog2(D):0]     cnt;
        logic                   done;

        // Reference: words waiting in the FIFO, cycles left in the current frame.
        logic [DW-1:0]          m_fifo[$];
        logic [DW-1:0]          m_word;
        int                     m_busy;
        logic                   m_ovf;
        logic                   m_full;
        logic [NB-1:0]          exp_q[$];

        int                     mon_cyc;
        logic [NB-1:0]          mon_bits;
        logic [NB-1:0]          exp_frame;
        logic                   mon_glitch;

        uart_tx_fifo_param #(
            .DATA_W       (DW),
            .CLKS_PER_BIT (C),
            .PARITY_EN    (PE),
            .PARITY_ODD   (PO),
            .STOP_BITS    (SB),
            .FIFO_DEPTH   (D)
        ) u_dut (
            .clk                (clk),
            .rst                (rst),
            .load               (load),
            .data_in            (din),
            .tx1                (tx),
            .parallel_in_active (act),
            .fifo_full          (full),
            .fifo_count         (cnt),
            .overflow           (ovf)
        );

        // Transmitted bit sequence of one frame, index 0 first on the line.
        function automatic logic [NB-1:0] frame_of(input logic [DW-1:0] w);
            logic [NB-1:0] f;
            f    = '1;
            f[0] = 1'b0;
            for (int i = 0; i < DW; i++) f[1 + i] = w[i];
            if (PE != 0) f[1 + DW] = (^w) ^ (PO != 0);
            return f;
        endfunction

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                m_fifo.delete();
                exp_q.delete();
                m_busy = 0;
                m_ovf  = 1'b0;
            end else begin
                m_full = (m_fifo.size() == D);
                if (m_busy <= 1 && m_fifo.size() > 0) begin
                    m_word = m_fifo.pop_front();
                    m_busy = FRAME;
                end else if (m_busy > 0) begin
                    m_busy--;
                end
                m_ovf = load && m_full;
                if (load && !m_full) begin
                    m_fifo.push_back(din);
                    exp_q.push_back(frame_of(din));
                end
            end
        end

        always @(negedge clk) begin
            if (rst) begin
                chk($sformatf("cfg%0d active", g), act, m_busy > 0);
                chk($sformatf("cfg%0d count", g), cnt, m_fifo.size());
                chk($sformatf("cfg%0d full", g), full, m_fifo.size() == D);
                chk($sformatf("cfg%0d overflow", g), ovf, m_ovf);
                if (!act) chk($sformatf("cfg%0d idle_line", g), tx, 1);
            end
        end

        // Monitor: collects one line sample per cycle while active, compares per frame.
        always @(negedge clk or negedge rst) begin
            if (!rst) begin
                mon_cyc    = 0;
                mon_glitch = 1'b0;
            end else if (act) begin
                if (mon_cyc % C == 0) mon_bits[mon_cyc / C] = tx;
                else if (tx !== mon_bits[mon_cyc / C]) mon_glitch = 1'b1;
                mon_cyc++;
                if (mon_cyc == FRAME) begin
                    chk($sformatf("cfg%0d frame_expected", g), exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp_frame = exp_q.pop_front();
                        chk($sformatf("cfg%0d frame_bits", g), mon_bits, exp_frame);
                    end
                    chk($sformatf("cfg%0d bit_stable", g), mon_glitch, 0);
                    mon_cyc    = 0;
                    mon_glitch = 1'b0;
                end
            end else if (mon_cyc != 0) begin
                chk($sformatf("cfg%0d frame_len", g), mon_cyc, FRAME);
                mon_cyc    = 0;
                mon_glitch = 1'b0;
            end
        end

        task automatic send(input int w);
            load = 1'b1;
            din  = DW'(w);
            @(negedge clk);
            load = 1'b0;
        endtask

        task automatic drain();
            int n;
            n = 0;
            while ((m_busy > 0 || m_fifo.size() > 0) && n < CYC_LIMIT) begin
                @(negedge clk);
                n++;
            end
            repeat (2) @(negedge clk);
            chk($sformatf("cfg%0d frames_left", g), exp_q.size(), 0);
        endtask

        initial begin
            load = 1'b0;
            din  = '0;
            done = 1'b0;
            wait (rst === 1'b1);
            @(negedge clk);
            if (g == 0) begin
                send('hA5);
                drain();
                send('h0F);
                send('hF0);
                drain();
                for (int i = 0; i < 6; i++) send(int'($urandom));
                drain();
            end else if (g == 3) begin
                send('h00);
                drain();
            end else begin
                send('hA5);
                drain();
                send(int'($urandom));
                send(int'($urandom));
                drain();
            end
            for (int i = 0; i < 300; i++) begin
                int rate;
                rate = ((i / 50) % 3) * 4;
                if ($urandom_range(0, rate) == 0) begin
                    load = 1'b1;
                    din  = DW'($urandom);
                end else begin
                    load = 1'b0;
                end
                @(negedge clk);
            end
            load = 1'b0;
            drain();
            done = 1'b1;
            if (g == 0) begin
                wait (rst_go === 1'b1);
                for (int i = 0; i < 3; i++) send(int'($urandom));
                repeat (50) @(negedge clk);
                rst_req = 1'b1;
                wait (rst_done === 1'b1);
            end
        end
    end

    assign all_done = g_cfg[0].done & g_cfg[1].done & g_cfg[2].done &
                      g_cfg[3].done & g_cfg[4].done & g_cfg[5].done;

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 60000 && !all_done; i++) @(negedge clk);
        if (!all_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL all_done: got 0 expected 1");
        end
        rst_go = 1'b1;
        for (int i = 0; i < 500 && !rst_req; i++) @(negedge clk);
        chk("rst_req_seen", rst_req, 1);
        @(negedge clk);
        chk("pre_reset_active", g_cfg[0].act, 1);
        chk("pre_reset_count", g_cfg[0].cnt, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_tx", g_cfg[0].tx, 1);
        chk("async_rst_active", g_cfg[0].act, 0);
        chk("async_rst_count", g_cfg[0].cnt, 0);
        chk("async_rst_full", g_cfg[0].full, 0);
        chk("async_rst_overflow", g_cfg[0].ovf, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_reset_tx", g_cfg[0].tx, 1);
            chk("post_reset_active", g_cfg[0].act, 0);
        end
        rst_done = 1'b1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
